// File: rtl/cordic_vectoring_seq.sv
// Iterative vectoring-mode CORDIC: Cartesian (x, y) in Q2.30 -> atan2 angle in Q3.29
// and K-scaled magnitude in Q4.30, one micro-rotation per clock behind start/busy/done.
//
// state  | meaning
// stIdle | waiting for start; operands pre-rotated into the right half-plane on accept
// stIter | one micro-rotation per cycle, i = 0..ITER-1
// stDone | publish angle and magnitude, pulse done, return to stIdle
module cordic_vectoring_seq #(
  parameter int ITER = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] angle_out,
  output logic signed [33:0] mag_out
);

  localparam logic signed [31:0] HalfPi    = 32'sh3243F6A9;
  localparam logic signed [31:0] NegHalfPi = 32'shCDBC0957;
  localparam logic [4:0]         LastIter  = 5'(ITER - 1);

  typedef enum logic [1:0] {stIdle, stIter, stDone} stateT;

  stateT              state;
  logic signed [33:0] xR;
  logic signed [33:0] yR;
  logic signed [31:0] zR;
  logic [4:0]         i;

  logic signed [33:0] xExt;
  logic signed [33:0] yExt;
  logic signed [33:0] xShift;
  logic signed [33:0] yShift;
  logic signed [31:0] atanI;

  // atan(2^-idx) in Q3.29, rounded to nearest
  function automatic logic signed [31:0] atanRom(input logic [4:0] idx);
    logic signed [31:0] v;
    case (idx)
      5'd0:    v = 32'sh1921FB54;
      5'd1:    v = 32'sh0ED63383;
      5'd2:    v = 32'sh07D6DD7E;
      5'd3:    v = 32'sh03FAB753;
      5'd4:    v = 32'sh01FF55BB;
      5'd5:    v = 32'sh00FFEAAE;
      5'd6:    v = 32'sh007FFD55;
      5'd7:    v = 32'sh003FFFAB;
      5'd8:    v = 32'sh001FFFF5;
      5'd9:    v = 32'sh000FFFFF;
      5'd10:   v = 32'sh00080000;
      5'd11:   v = 32'sh00040000;
      5'd12:   v = 32'sh00020000;
      5'd13:   v = 32'sh00010000;
      5'd14:   v = 32'sh00008000;
      5'd15:   v = 32'sh00004000;
      5'd16:   v = 32'sh00002000;
      5'd17:   v = 32'sh00001000;
      5'd18:   v = 32'sh00000800;
      5'd19:   v = 32'sh00000400;
      5'd20:   v = 32'sh00000200;
      5'd21:   v = 32'sh00000100;
      5'd22:   v = 32'sh00000080;
      5'd23:   v = 32'sh00000040;
      5'd24:   v = 32'sh00000020;
      5'd25:   v = 32'sh00000010;
      5'd26:   v = 32'sh00000008;
      5'd27:   v = 32'sh00000004;
      5'd28:   v = 32'sh00000002;
      5'd29:   v = 32'sh00000001;
      default: v = 32'sh00000000;
    endcase
    return v;
  endfunction

  // Two guard bits let -(-2.0) and the K-scaled magnitude fit without overflow
  assign xExt   = {{2{x_in[31]}}, x_in};
  assign yExt   = {{2{y_in[31]}}, y_in};
  assign xShift = xR >>> i;
  assign yShift = yR >>> i;
  assign atanI  = atanRom(i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= stIdle;
      xR        <= '0;
      yR        <= '0;
      zR        <= '0;
      i         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        stIdle: begin
          if (start) begin
            i     <= '0;
            busy  <= 1'b1;
            state <= stIter;
            if (!x_in[31]) begin
              xR <= xExt;
              yR <= yExt;
              zR <= '0;
            end else if (!y_in[31]) begin
              xR <= yExt;
              yR <= -xExt;
              zR <= HalfPi;
            end else begin
              xR <= -yExt;
              yR <= xExt;
              zR <= NegHalfPi;
            end
          end
        end
        stIter: begin
          // y = 0 rotates clockwise, so (-x, 0) lands on +pi rather than -pi
          if (!yR[33]) begin
            xR <= xR + yShift;
            yR <= yR - xShift;
            zR <= zR + atanI;
          end else begin
            xR <= xR - yShift;
            yR <= yR + xShift;
            zR <= zR - atanI;
          end
          i <= i + 5'd1;
          if (i == LastIter) state <= stDone;
        end
        stDone: begin
          angle_out <= zR;
          mag_out   <= xR;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= stIdle;
        end
        default: state <= stIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_seq.sv
// Bench for cordic_vectoring_seq: real-valued atan2/magnitude model with a cycle schedule,
// checked every cycle, plus directed literal points, handshake cases and a 5-degree sweep.
module tb_cordic_vectoring_seq;

  localparam int  ITER   = 16;
  localparam real Q29    = 536870912.0;
  localparam real Q30    = 1073741824.0;
  localparam real Pi     = 3.14159265358979323846;
  // final-step residual is bounded by atan(2^-15); the small extra covers truncation noise
  localparam real AngTol = 16640.0;
  localparam real MagTol = 32768.0;

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [31:0]        x_in  = '0;
  logic [31:0]        y_in  = '0;
  logic               busy;
  logic               done;
  logic signed [31:0] angle_out;
  logic signed [33:0] mag_out;

  cordic_vectoring_seq #(.ITER(ITER)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .angle_out (angle_out),
    .mag_out   (mag_out)
  );

  always #5 clk = ~clk;

  int  nChecks = 0;
  int  nErrors = 0;
  real gainK   = 1.0;

  int  edgeNo     = 0;
  int  acceptEdge = -1000;
  bit  resValid   = 1'b0;
  bit  resZero    = 1'b0;
  real resAng     = 0.0;
  real resMag     = 0.0;
  bit  pendZero   = 1'b0;
  real pendAng    = 0.0;
  real pendMag    = 0.0;

  task automatic checkEq(input string nm, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic checkNear(input string nm, input longint act, input real exp, input real tol);
    real d;
    nChecks++;
    d = real'(act) - exp;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0.1f (+/- %0.0f)", nm, act, exp, tol);
    end
  endtask

  // Reference: a request is taken when no conversion is outstanding; the result
  // appears ITER+1 edges later and the unit can accept again one edge after that.
  always @(posedge clk) begin
    if (!reset) begin
      edgeNo++;
      if (start && edgeNo >= acceptEdge + ITER + 2) begin
        real xr, yr;
        xr         = real'($signed(x_in));
        yr         = real'($signed(y_in));
        acceptEdge = edgeNo;
        pendZero   = (x_in == 32'd0) && (y_in == 32'd0);
        pendAng    = $atan2(yr, xr) * Q29;
        pendMag    = gainK * $sqrt(xr * xr + yr * yr);
      end
      if (edgeNo == acceptEdge + ITER + 1) begin
        resValid = 1'b1;
        resZero  = pendZero;
        resAng   = pendAng;
        resMag   = pendMag;
      end
    end
  end

  always @(posedge reset) begin
    acceptEdge = -1000;
    resValid   = 1'b0;
  end

  always @(negedge clk) begin
    if (reset) begin
      checkEq("reset busy", longint'(busy), 0);
      checkEq("reset done", longint'(done), 0);
      checkEq("reset angle", longint'(angle_out), 0);
      checkEq("reset mag", longint'(mag_out), 0);
    end else begin
      checkEq("busy", longint'(busy),
              longint'(edgeNo >= acceptEdge && edgeNo <= acceptEdge + ITER));
      checkEq("done", longint'(done), longint'(edgeNo == acceptEdge + ITER + 1));
      if (resValid) begin
        if (!resZero) checkNear("model angle", longint'(angle_out), resAng, AngTol);
        checkNear("model mag", longint'(mag_out), resMag, MagTol);
      end else begin
        checkEq("idle angle", longint'(angle_out), 0);
        checkEq("idle mag", longint'(mag_out), 0);
      end
    end
  end

  task automatic convert(input logic [31:0] x, input logic [31:0] y);
    int lat;
    @(negedge clk);
    start = 1'b1;
    x_in  = x;
    y_in  = y;
    @(negedge clk);
    start = 1'b0;
    x_in  = $urandom;
    y_in  = $urandom;
    lat   = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkEq("latency", lat, ITER + 1);
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkEq("idle wait", longint'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nDone;
    int cyc;
    int first;
    int second;

    for (int k = 0; k < ITER; k++) gainK = gainK * $sqrt(1.0 + 1.0 / (4.0 ** k));

    repeat (3) @(negedge clk);
    checkEq("por busy", longint'(busy), 0);
    checkEq("por done", longint'(done), 0);
    checkEq("por angle", longint'(angle_out), 0);
    checkEq("por mag", longint'(mag_out), 0);
    #2 reset = 1'b0;

    convert(32'h40000000, 32'h00000000);
    checkNear("(1,0) angle", longint'(angle_out), 0.0, AngTol);
    checkNear("(1,0) mag", longint'(mag_out), 1768195365.0, MagTol);

    convert(32'h40000000, 32'h40000000);
    checkNear("(1,1) angle", longint'(angle_out), 421657428.0, AngTol);
    checkNear("(1,1) mag", longint'(mag_out), 2500605700.0, MagTol);

    convert(32'hC0000000, 32'h00000000);
    checkNear("(-1,0) angle", longint'(angle_out), 1686629713.0, AngTol);

    convert(32'h00000000, 32'hC0000000);
    checkNear("(0,-1) angle", longint'(angle_out), -843314857.0, AngTol);

    convert(32'h80000000, 32'h00000000);
    checkNear("(-2,0) angle", longint'(angle_out), 1686629713.0, AngTol);
    checkNear("(-2,0) mag", longint'(mag_out), 3536390730.0, MagTol);

    convert(32'h00000000, 32'h00000000);
    checkEq("(0,0) mag", longint'(mag_out), 0);

    // second start five cycles in must be dropped
    @(negedge clk);
    start = 1'b1;
    x_in  = 32'h40000000;
    y_in  = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    x_in  = 32'hC0000000;
    y_in  = 32'h00000000;
    @(negedge clk);
    start = 1'b0;
    nDone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) begin
        nDone++;
        if (nDone == 1) checkNear("ignored start angle", longint'(angle_out), 421657428.0, AngTol);
      end
    end
    checkEq("ignored start done count", nDone, 1);

    // start held high: back-to-back results
    @(negedge clk);
    start  = 1'b1;
    x_in   = 32'h20000000;
    y_in   = 32'hE0000000;
    nDone  = 0;
    cyc    = 0;
    first  = 0;
    second = 0;
    while (nDone < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (nDone == 0) first = cyc;
        else second = cyc;
        nDone++;
      end
    end
    start = 1'b0;
    checkEq("b2b done count", nDone, 2);
    checkEq("b2b spacing", second - first, ITER + 2);
    waitIdle();

    // reset in the middle of a conversion
    @(negedge clk);
    start = 1'b1;
    x_in  = 32'h40000000;
    y_in  = 32'h00000000;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkEq("abort busy", longint'(busy), 0);
    checkEq("abort done", longint'(done), 0);
    checkEq("abort angle", longint'(angle_out), 0);
    checkEq("abort mag", longint'(mag_out), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    nDone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nDone++;
    end
    checkEq("abort done pulses", nDone, 0);

    for (int d = 0; d < 360; d += 5) begin
      real th;
      logic [31:0] xs;
      logic [31:0] ys;
      th = real'(d) * Pi / 180.0;
      xs = 32'(longint'($cos(th) * Q30));
      ys = 32'(longint'($sin(th) * Q30));
      convert(xs, ys);
      if (d > 180) th = th - 2.0 * Pi;
      checkNear($sformatf("sweep %0d angle", d), longint'(angle_out), th * Q29, AngTol);
      checkNear($sformatf("sweep %0d mag", d), longint'(mag_out), gainK * Q30, MagTol);
    end

    repeat (40) begin
      logic [31:0] rx;
      logic [31:0] ry;
      int tries;
      real mr;
      tries = 0;
      do begin
        rx    = $urandom;
        ry    = $urandom;
        mr    = $sqrt(real'($signed(rx)) * real'($signed(rx)) + real'($signed(ry)) * real'($signed(ry)));
        tries++;
      end while (tries < 20 && mr < 0.25 * Q30);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      convert(rx, ry);
    end

    waitIdle();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
